jtag_scan_sequencer: RTL and testbench

// - Single-clock JTAG master that sequences IR-scan + DR-scan transactions into a debug TAP.
// - Targets the DMI TAP (IDCODE/DTMCS/DMI/BYPASS) for FPGA self-test and boot-loading with no external probe.
// - Command in via valid/ready: IR value, DR data, DR length. Response out via valid/ready: captured DR bits.
// - Generates tck/tms/tdi and samples tdo.

---
 rtl/jtag_scan_sequencer_if.sv | 36 +++
 rtl/jtag_scan_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_jtag_scan_sequencer.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_scan_sequencer_if.sv
// Command/response bus between a host and the JTAG scan sequencer.
//
// Handshake: a transfer happens on a clk_i edge where valid and ready are both
// high. The producer holds valid (and the payload) stable until that edge; the
// consumer may raise or drop ready at any time. cmd_* is produced by the host,
// rsp_* by the sequencer.
interface jtag_scan_sequencer_if #(
  parameter int IrLength = 5,
  parameter int DrMaxLen = 64
);
  localparam int LenW = $clog2(DrMaxLen + 1);

  logic                cmd_valid_i;
  logic                cmd_ready_o;
  logic                cmd_reset_i;
  logic [IrLength-1:0] cmd_ir_i;
  logic [DrMaxLen-1:0] cmd_dr_i;
  logic [LenW-1:0]     cmd_dr_len_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i;
  logic [DrMaxLen-1:0] rsp_dr_o;
  logic                busy_o;
  logic [3:0]          state_dbg_o;

  // Host side.
  modport master (
    output cmd_valid_i, cmd_reset_i, cmd_ir_i, cmd_dr_i, cmd_dr_len_i, rsp_ready_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dr_o, busy_o, state_dbg_o
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid_i, cmd_reset_i, cmd_ir_i, cmd_dr_i, cmd_dr_len_i, rsp_ready_i,
    output cmd_ready_o, rsp_valid_o, rsp_dr_o, busy_o, state_dbg_o
  );
endinterface

// File: rtl/jtag_scan_sequencer.sv
// Single-clock JTAG master: optional Test-Logic-Reset, IR scan, optional DR
// scan, then returns the captured DR bits. TCK is divided from clk_i; TMS/TDI
// change on TCK fall, TDO is sampled and the TAP position advances on TCK rise.
module jtag_scan_sequencer #(
  parameter int ClkDiv   = 4,
  parameter int IrLength = 5,
  parameter int DrMaxLen = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  jtag_scan_sequencer_if.slave        bus,
  output logic                        tck_o,
  output logic                        tms_o,
  output logic                        tdi_o,
  input  logic                        tdo_i,
  output logic                        trst_no
);
  localparam int LenW   = $clog2(DrMaxLen + 1);
  localparam int MaxLen = (IrLength > DrMaxLen) ? IrLength : DrMaxLen;
  localparam int IdxW   = $clog2(MaxLen + 1);
  localparam int CntW   = $clog2(ClkDiv);

  typedef enum logic [3:0] {
    ST_IDLE, ST_TLR, ST_IR_HDR, ST_IR_SHIFT, ST_IR_TAIL,
    ST_DR_HDR, ST_DR_SHIFT, ST_DR_TAIL, ST_DONE, ST_RSP
  } state_t;

  state_t              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic [IrLength-1:0] ir_q, ir_d;
  logic [DrMaxLen-1:0] dr_q, dr_d, cap_q, cap_d, rsp_dr_q, rsp_dr_d;
  logic [LenW-1:0]     n_q, n_d;
  logic                synced_q, synced_d, rsp_valid_q, rsp_valid_d;
  logic                ready_q, ready_d, busy_q, busy_d, trst_q;

  logic wrap, last_n, last_step, step_tms, step_tdi;

  // TMS/TDI for the TCK at the current position, and whether it ends its phase.
  always_comb begin
    last_n    = (idx_q == IdxW'(n_q) - IdxW'(1));
    step_tms  = 1'b0;
    last_step = 1'b0;
    step_tdi  = 1'b0;
    case (state_q)
      ST_TLR:      begin step_tms = (idx_q < IdxW'(5)); last_step = (idx_q == IdxW'(5)); end
      ST_IR_HDR:   begin step_tms = (idx_q < IdxW'(2)); last_step = (idx_q == IdxW'(3)); end
      ST_IR_SHIFT: begin
        step_tms  = (idx_q == IdxW'(IrLength - 1));
        last_step = step_tms;
        step_tdi  = ir_q[0];
      end
      ST_IR_TAIL:  begin step_tms = (idx_q == '0); last_step = (idx_q == IdxW'(1)); end
      ST_DR_HDR:   begin step_tms = (idx_q == '0); last_step = (idx_q == IdxW'(2)); end
      ST_DR_SHIFT: begin step_tms = last_n; last_step = last_n; step_tdi = dr_q[0]; end
      ST_DR_TAIL:  begin step_tms = (idx_q == '0); last_step = (idx_q == IdxW'(1)); end
      default:     begin step_tms = 1'b0; last_step = 1'b0; end
    endcase
  end

  // Next-state: command accept, TCK generation, per-edge TAP sequencing, response.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tck_d       = tck_q;
    tms_d       = tms_q;
    tdi_d       = tdi_q;
    ir_d        = ir_q;
    dr_d        = dr_q;
    n_d         = n_q;
    cap_d       = cap_q;
    synced_d    = synced_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dr_d    = rsp_dr_q;
    wrap        = (cnt_q == CntW'(ClkDiv - 1));
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i && ready_q) begin
          ir_d    = bus.cmd_ir_i;
          dr_d    = bus.cmd_dr_i;
          n_d     = (bus.cmd_dr_len_i > LenW'(DrMaxLen)) ? LenW'(DrMaxLen) : bus.cmd_dr_len_i;
          cap_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          tck_d   = 1'b0;
          tms_d   = 1'b1;
          tdi_d   = 1'b0;
          state_d = (bus.cmd_reset_i || !synced_q) ? ST_TLR : ST_IR_HDR;
        end
      end
      ST_RSP: begin
        if (bus.rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        if (wrap) begin
          cnt_d = '0;
          tck_d = ~tck_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
        // TCK rise: sample TDO and step to the next TAP position.
        if (wrap && !tck_q) begin
          if (state_q == ST_DR_SHIFT) begin
            cap_d = cap_q | (DrMaxLen'(tdo_i) << idx_q);
            dr_d  = dr_q >> 1;
          end
          if (state_q == ST_IR_SHIFT) ir_d = ir_q >> 1;
          idx_d = idx_q + IdxW'(1);
          if (last_step) begin
            idx_d = '0;
            case (state_q)
              ST_TLR:      begin state_d = ST_IR_HDR; synced_d = 1'b1; end
              ST_IR_HDR:   state_d = ST_IR_SHIFT;
              ST_IR_SHIFT: state_d = ST_IR_TAIL;
              ST_IR_TAIL:  state_d = (n_q == '0) ? ST_DONE : ST_DR_HDR;
              ST_DR_HDR:   state_d = ST_DR_SHIFT;
              ST_DR_SHIFT: state_d = ST_DR_TAIL;
              default:     state_d = ST_DONE;
            endcase
          end
        end
        // TCK fall: present TMS/TDI for the next TCK, or finish after the last one.
        if (wrap && tck_q) begin
          if (state_q == ST_DONE) begin
            state_d     = ST_RSP;
            rsp_valid_d = 1'b1;
            rsp_dr_d    = cap_q;
            tms_d       = 1'b0;
            tdi_d       = 1'b0;
          end else begin
            tms_d = step_tms;
            tdi_d = step_tdi;
          end
        end
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // All sequencer state; reset returns every output to its idle value at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ir_q        <= '0;
      dr_q        <= '0;
      n_q         <= '0;
      cap_q       <= '0;
      synced_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dr_q    <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      trst_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tck_q       <= tck_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ir_q        <= ir_d;
      dr_q        <= dr_d;
      n_q         <= n_d;
      cap_q       <= cap_d;
      synced_q    <= synced_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dr_q    <= rsp_dr_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      trst_q      <= 1'b1;
    end
  end

  assign tck_o           = tck_q;
  assign tms_o           = tms_q;
  assign tdi_o           = tdi_q;
  assign trst_no         = trst_q;
  assign bus.cmd_ready_o = ready_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dr_o    = rsp_dr_q;
  assign bus.busy_o      = busy_q;
  assign bus.state_dbg_o = state_q;
endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: drives it against a behavioural DMI TAP.
module tb_jtag_scan_sequencer;
  localparam int ClkDiv   = 4;
  localparam int IrLength = 5;
  localparam int DrMaxLen = 64;
  localparam int LenW     = $clog2(DrMaxLen + 1);
  localparam logic [31:0] IdcodeValue = 32'h249511C3;
  localparam logic [31:0] DtmcsValue  = 32'h00005071;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi, trst_n;
  logic tdo = 1'b0;
  always #5 clk = ~clk;

  jtag_scan_sequencer_if #(.IrLength(IrLength), .DrMaxLen(DrMaxLen)) bus ();

  jtag_scan_sequencer #(.ClkDiv(ClkDiv), .IrLength(IrLength), .DrMaxLen(DrMaxLen)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .tck_o(tck), .tms_o(tms), .tdi_o(tdi), .tdo_i(tdo), .trst_no(trst_n)
  );

  // ---------------- DMI TAP model ----------------
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_t;
  tap_t        tap_st = TLR;
  logic [4:0]  tap_ir = 5'h01;
  logic [4:0]  tap_ir_sr = 5'h0;
  logic [63:0] tap_dr_sr = 64'h0;
  int          tap_dr_len = 1;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:    return m ? TLR    : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PAU_DR;
      PAU_DR: return m ? EX2_DR : PAU_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR    : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PAU_IR;
      PAU_IR: return m ? EX2_IR : PAU_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tap_st <= TLR;
      tap_ir <= 5'h01;
    end else begin
      case (tap_st)
        TLR:    tap_ir <= 5'h01;
        CAP_IR: tap_ir_sr <= 5'b00001;
        SH_IR:  tap_ir_sr <= {tdi, tap_ir_sr[4:1]};
        UPD_IR: tap_ir <= tap_ir_sr;
        CAP_DR: begin
          case (tap_ir)
            5'h01:   begin tap_dr_sr <= {32'h0, IdcodeValue}; tap_dr_len <= 32; end
            5'h10:   begin tap_dr_sr <= {32'h0, DtmcsValue};  tap_dr_len <= 32; end
            5'h11:   begin tap_dr_sr <= 64'h0;                tap_dr_len <= 41; end
            default: begin tap_dr_sr <= 64'h0;                tap_dr_len <= 1;  end
          endcase
        end
        SH_DR: tap_dr_sr <= (tap_dr_sr >> 1) | (64'(tdi) << (tap_dr_len - 1));
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms);
    end
  end

  always @(negedge tck or negedge trst_n) begin
    if (!trst_n) tdo <= 1'b0;
    else tdo <= (tap_st == SH_DR) ? tap_dr_sr[0] : (tap_st == SH_IR) ? tap_ir_sr[0] : 1'b0;
  end

  // ---------------- monitors ----------------
  int   cyc = 0;
  int   rises = 0;
  int   proto_err = 0;
  logic tck_prev = 1'b0, tms_prev = 1'b1, tdi_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // TCK rise counter and setup/hold check: TMS/TDI may only move while TCK is low.
  always @(negedge clk) begin
    if (tck === 1'b1 && tck_prev === 1'b0) rises <= rises + 1;
    if (tck === 1'b1 && (tms !== tms_prev || tdi !== tdi_prev)) proto_err <= proto_err + 1;
    tck_prev <= tck;
    tms_prev <= tms;
    tdi_prev <= tdi;
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_scan(input logic rs, input logic [4:0] ir, input logic [63:0] dr,
                         input logic [LenW-1:0] len, input int hold,
                         output logic [63:0] got, output int tcks, output int lat,
                         output logic busy_mid);
    int acc_cyc, acc_rises, n;
    int st_valid, st_dr, st_ready, st_tck;
    got = '0; tcks = 0; lat = 0; busy_mid = 1'b0;
    @(negedge clk);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_reset_i  = rs;
    bus.cmd_ir_i     = ir;
    bus.cmd_dr_i     = dr;
    bus.cmd_dr_len_i = len;
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("cmd_accept_wait", 64'(bus.cmd_ready_o === 1'b1), 64'd1);
    @(posedge clk); #1;
    acc_cyc   = cyc;
    acc_rises = rises;
    @(negedge clk);
    busy_mid = bus.busy_o;
    // Scramble the command fields; the scan must use the latched values.
    bus.cmd_valid_i  = 1'b0;
    bus.cmd_reset_i  = 1'($urandom_range(0, 1));
    bus.cmd_ir_i     = 5'($urandom_range(0, 31));
    bus.cmd_dr_i     = {32'($urandom), 32'($urandom)};
    bus.cmd_dr_len_i = LenW'($urandom_range(0, 64));
    n = 0;
    while (bus.rsp_valid_o !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    check("rsp_wait", 64'(bus.rsp_valid_o === 1'b1), 64'd1);
    lat  = cyc - acc_cyc;
    tcks = rises - acc_rises;
    got  = bus.rsp_dr_o;
    if (hold > 0) begin
      st_valid = 0; st_dr = 0; st_ready = 0; st_tck = 0;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        if (bus.rsp_valid_o !== 1'b1) st_valid++;
        if (bus.rsp_dr_o !== got) st_dr++;
        if (bus.cmd_ready_o !== 1'b0) st_ready++;
        if (tck !== 1'b0) st_tck++;
      end
      check("bp_rsp_valid_drops", 64'(st_valid), 64'd0);
      check("bp_rsp_dr_changes", 64'(st_dr), 64'd0);
      check("bp_cmd_ready_high", 64'(st_ready), 64'd0);
      check("bp_tck_moves", 64'(st_tck), 64'd0);
      check("bp_no_extra_tck", 64'(rises - acc_rises), 64'(tcks));
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic            rs;
    logic [4:0]      ir;
    logic [63:0]     dr;
    logic [LenW-1:0] len;
    logic [63:0]     exp_dr;
    int              exp_tcks;
    int              exp_lat;
  } vec_t;

  localparam int NumVec = 8;
  vec_t vecs[NumVec];

  logic [63:0] got;
  int          tcks, lat, n, acc_rises, seen_rsp;
  logic        busy_mid;

  initial begin
    // IDCODE first after reset: forced TLR, 6+11+37 TCKs.
    vecs[0] = '{1'b0, 5'h01, 64'h0,                  7'd32, 64'h249511C3,         54, 432};
    // BYPASS: leading captured 0, data delayed one bit.
    vecs[1] = '{1'b0, 5'h1F, 64'hA5,                 7'd8,  64'h4A,               24, 192};
    // IR-only scan selects DTMCS.
    vecs[2] = '{1'b0, 5'h10, 64'hFFFF,               7'd0,  64'h0,                11, 88};
    vecs[3] = '{1'b0, 5'h10, 64'h0,                  7'd32, 64'h00005071,         48, 384};
    // Explicit TLR request on an already synced link.
    vecs[4] = '{1'b1, 5'h10, 64'h0,                  7'd32, 64'h00005071,         54, 432};
    // Length 65 clamps to 64 shift TCKs through BYPASS.
    vecs[5] = '{1'b0, 5'h1F, 64'hDEADBEEF01234567,   7'd65, 64'hBD5B7DDE02468ACE, 80, 640};
    // Partial IDCODE read.
    vecs[6] = '{1'b0, 5'h01, 64'h0,                  7'd16, 64'h11C3,             32, 256};
    // Single-bit BYPASS scan returns only the captured 0.
    vecs[7] = '{1'b0, 5'h1F, 64'h1,                  7'd1,  64'h0,                17, 136};

    bus.cmd_valid_i  = 1'b0;
    bus.cmd_reset_i  = 1'b0;
    bus.cmd_ir_i     = '0;
    bus.cmd_dr_i     = '0;
    bus.cmd_dr_len_i = '0;
    bus.rsp_ready_i  = 1'b0;

    // Reset state.
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tck", 64'(tck), 64'd0);
    check("rst_tms", 64'(tms), 64'd1);
    check("rst_tdi", 64'(tdi), 64'd0);
    check("rst_trst_n", 64'(trst_n), 64'd0);
    check("rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    check("rst_rsp_dr", bus.rsp_dr_o, 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", 64'(bus.cmd_ready_o), 64'd1);
    check("post_rst_trst_n", 64'(trst_n), 64'd1);
    acc_rises = rises;
    repeat (10) @(negedge clk);
    check("idle_no_tck", 64'(rises - acc_rises), 64'd0);
    check("idle_tms_high", 64'(tms), 64'd1);

    // Table-driven scans.
    for (int i = 0; i < NumVec; i++) begin
      do_scan(vecs[i].rs, vecs[i].ir, vecs[i].dr, vecs[i].len, 0, got, tcks, lat, busy_mid);
      check($sformatf("v%0d_rsp_dr", i), got, vecs[i].exp_dr);
      check($sformatf("v%0d_tcks", i), 64'(tcks), 64'(vecs[i].exp_tcks));
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy_mid", i), 64'(busy_mid), 64'd1);
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), 64'(bus.cmd_ready_o), 64'd1);
      check($sformatf("v%0d_busy_after", i), 64'(bus.busy_o), 64'd0);
    end

    // Response backpressure for 20 clk.
    do_scan(1'b0, 5'h1F, 64'h3C, 7'd8, 20, got, tcks, lat, busy_mid);
    check("bp_rsp_dr", got, 64'h78);
    check("bp_tcks", 64'(tcks), 64'd24);

    // Reset in the middle of DR_SHIFT (during bit 10 of 32).
    @(negedge clk);
    bus.cmd_valid_i  = 1'b1;
    bus.cmd_reset_i  = 1'b0;
    bus.cmd_ir_i     = 5'h01;
    bus.cmd_dr_i     = '0;
    bus.cmd_dr_len_i = 7'd32;
    n = 0;
    while (bus.cmd_ready_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    acc_rises = rises;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    n = 0;
    while ((rises - acc_rises) < 25 && n < 2000) begin @(negedge clk); n++; end
    check("mid_reach_bit10", 64'(rises - acc_rises), 64'd25);
    check("mid_busy_before", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_tck", 64'(tck), 64'd0);
    check("mid_rst_tms", 64'(tms), 64'd1);
    check("mid_rst_busy", 64'(bus.busy_o), 64'd0);
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_rsp = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.rsp_valid_o === 1'b1) seen_rsp++;
    end
    check("mid_no_rsp", 64'(seen_rsp), 64'd0);
    do_scan(1'b0, 5'h01, 64'h0, 7'd32, 0, got, tcks, lat, busy_mid);
    check("post_mid_rsp_dr", got, 64'h249511C3);
    check("post_mid_tcks_tlr", 64'(tcks), 64'd54);
    check("post_mid_latency", 64'(lat), 64'd432);

    // TMS/TDI never moved while TCK was high over the whole run.
    @(negedge clk);
    check("proto_tms_tdi_on_fall", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
